transmissor_senha: RTL and testbench



---
 rtl/transmissor_senha.sv | 132 +++++++++++++
 tb/tb_transmissor_senha.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/transmissor_senha.sv
// rtl/transmissor_senha.sv - sends the stored 6-digit code as insere strobes on numero
// An optional inverted digit lets a bench exercise the lock's error path.
module transmissor_senha #(
  parameter logic [3:0]  D0        = 4'd5,
  parameter logic [3:0]  D1        = 4'd9,
  parameter logic [3:0]  D2        = 4'd0,
  parameter logic [3:0]  D3        = 4'd9,
  parameter logic [3:0]  D4        = 4'd8,
  parameter logic [3:0]  D5        = 4'd1,
  parameter int unsigned INTERVALO = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicia,
  input  logic       injeta_erro,
  input  logic [2:0] pos_erro,
  output logic [4:1] numero,
  output logic       insere,
  output logic [2:0] indice,
  output logic       ocupado,
  output logic       fim
);

  typedef enum logic [1:0] {OCIOSO, ENVIA, ESPERA, FIM} t_estado;

  localparam logic [3:0] LP_INTERVALO = 4'(INTERVALO);

  t_estado    r_estado;
  logic [3:0] r_cnt;
  logic [2:0] r_indice;
  logic       r_err_en;
  logic [2:0] r_err_pos;
  logic [3:0] r_numero;
  logic       r_insere;
  logic       r_ocupado;
  logic       r_fim;

  t_estado    w_estado_prox;
  logic [3:0] w_cnt_prox;
  logic [2:0] w_indice_prox;
  logic       w_err_en_prox;
  logic [2:0] w_err_pos_prox;
  logic [3:0] w_digito;
  logic [3:0] w_numero_prox;

  function automatic logic [3:0] f_digito(input logic [2:0] idx);
    case (idx)
      3'd0:    return D0;
      3'd1:    return D1;
      3'd2:    return D2;
      3'd3:    return D3;
      3'd4:    return D4;
      3'd5:    return D5;
      default: return 4'd0;
    endcase
  endfunction

  always_comb begin
    w_estado_prox  = r_estado;
    w_cnt_prox     = r_cnt;
    w_indice_prox  = r_indice;
    w_err_en_prox  = r_err_en;
    w_err_pos_prox = r_err_pos;
    case (r_estado)
      OCIOSO: begin
        if (inicia) begin
          w_err_en_prox  = injeta_erro;
          w_err_pos_prox = pos_erro;
          w_indice_prox  = 3'd0;
          w_estado_prox  = ENVIA;
        end
      end
      ENVIA: begin
        if (r_indice == 3'd5) begin
          w_estado_prox = FIM;
        end else begin
          w_cnt_prox    = LP_INTERVALO;
          w_estado_prox = ESPERA;
        end
      end
      ESPERA: begin
        // <= 1 keeps an out-of-range INTERVALO of 0 from wrapping into a 16-cycle wait
        if (r_cnt <= 4'd1) begin
          w_indice_prox = 3'(r_indice + 3'd1);
          w_estado_prox = ENVIA;
        end else begin
          w_cnt_prox = 4'(r_cnt - 4'd1);
        end
      end
      FIM:     w_estado_prox = OCIOSO;
      default: w_estado_prox = OCIOSO;
    endcase

    // Outputs are registered from the next state so ENVIA and its strobe share a cycle
    w_digito      = f_digito(w_indice_prox);
    w_numero_prox = r_numero;
    if (w_estado_prox == ENVIA) begin
      w_numero_prox = (w_err_en_prox && (w_err_pos_prox == w_indice_prox)) ? ~w_digito : w_digito;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_estado  <= OCIOSO;
      r_cnt     <= 4'd0;
      r_indice  <= 3'd0;
      r_err_en  <= 1'b0;
      r_err_pos <= 3'd0;
      r_numero  <= 4'd0;
      r_insere  <= 1'b0;
      r_ocupado <= 1'b0;
      r_fim     <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_cnt     <= w_cnt_prox;
      r_indice  <= w_indice_prox;
      r_err_en  <= w_err_en_prox;
      r_err_pos <= w_err_pos_prox;
      r_numero  <= w_numero_prox;
      r_insere  <= (w_estado_prox == ENVIA);
      r_ocupado <= (w_estado_prox != OCIOSO);
      r_fim     <= (w_estado_prox == FIM);
    end
  end

  assign numero  = r_numero;
  assign insere  = r_insere;
  assign indice  = r_indice;
  assign ocupado = r_ocupado;
  assign fim     = r_fim;

endmodule

// File: tb/tb_transmissor_senha.sv
// tb/tb_transmissor_senha.sv - scoreboard bench for transmissor_senha
module tb_transmissor_senha;

  typedef struct {
    int         cyc;
    bit         is_fim;
    logic [3:0] num;
    logic [2:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicia0 = 1'b0, injeta0 = 1'b0;
  logic [2:0] pos0 = 3'd0;
  logic       inicia1 = 1'b0, injeta1 = 1'b0;
  logic [2:0] pos1 = 3'd0;

  logic [4:1] numero0, numero1;
  logic       insere0, insere1, ocupado0, ocupado1, fim0, fim1;
  logic [2:0] indice0, indice1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   prev0 = 1'b0, prev1 = 1'b0;
  logic [3:0] dig [6] = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};

  transmissor_senha u_dut0 (
    .clk(clk), .reset(reset), .inicia(inicia0), .injeta_erro(injeta0), .pos_erro(pos0),
    .numero(numero0), .insere(insere0), .indice(indice0), .ocupado(ocupado0), .fim(fim0)
  );

  transmissor_senha #(.INTERVALO(1)) u_dut1 (
    .clk(clk), .reset(reset), .inicia(inicia1), .injeta_erro(injeta1), .pos_erro(pos1),
    .numero(numero1), .insere(insere1), .indice(indice1), .ocupado(ocupado1), .fim(fim1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_tx(input int sel, input int c0, input int intv, input int n_str,
                         input bit with_fim, input bit err, input int pos);
    exp_t e;
    for (int n = 0; n < n_str; n++) begin
      e.cyc    = c0 + 1 + n * (intv + 1);
      e.is_fim = 1'b0;
      e.idx    = 3'(n);
      e.num    = (err && pos == n) ? ~dig[n] : dig[n];
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (with_fim) begin
      e.cyc    = c0 + 2 + 5 * (intv + 1);
      e.is_fim = 1'b1;
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start0(input bit err, input logic [2:0] pos, output int c0);
    c0      = cyc;
    inicia0 = 1'b1;
    injeta0 = err;
    pos0    = pos;
    @(posedge clk);
    #1;
    inicia0 = 1'b0;
    injeta0 = 1'b0;
    pos0    = 3'd0;
  endtask

  // Each strobe or fim pulse must match the head of the scoreboard in cycle and content
  always @(negedge clk) begin
    exp_t e;
    if (insere0 || fim0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_pulse", {30'd0, insere0, fim0}, 32'd0);
      end else begin
        e = q0.pop_front();
        check("dut0_cycle", cyc, e.cyc);
        check("dut0_fim", fim0, e.is_fim);
        check("dut0_numero", numero0, e.num);
        check("dut0_indice", indice0, e.idx);
      end
    end
    check("dut0_insere_b2b", insere0 & prev0, 0);
    prev0 = insere0;

    if (insere1 || fim1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_pulse", {30'd0, insere1, fim1}, 32'd0);
      end else begin
        e = q1.pop_front();
        check("dut1_cycle", cyc, e.cyc);
        check("dut1_fim", fim1, e.is_fim);
        check("dut1_numero", numero1, e.num);
        check("dut1_indice", indice1, e.idx);
      end
    end
    check("dut1_insere_b2b", insere1 & prev1, 0);
    prev1 = insere1;
  end

  initial begin
    int c0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_numero", numero0, 0);
    check("rst_insere", insere0, 0);
    check("rst_indice", indice0, 0);
    check("rst_ocupado", ocupado0, 0);
    check("rst_fim", fim0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Default sequence
    start0(1'b0, 3'd0, c0);
    push_tx(0, c0, 3, 6, 1'b1, 1'b0, 0);
    wait_until(c0 + 22);
    check("s1_ocupado_fim_cycle", ocupado0, 1);
    wait_until(c0 + 23);
    check("s1_ocupado_after", ocupado0, 0);
    check("s1_numero_hold", numero0, 1);
    check("s1_indice_hold", indice0, 5);
    wait_until(c0 + 26);

    // Third digit inverted
    start0(1'b1, 3'd2, c0);
    push_tx(0, c0, 3, 6, 1'b1, 1'b1, 2);
    wait_until(c0 + 26);

    // Out-of-range position corrupts nothing
    start0(1'b1, 3'd6, c0);
    push_tx(0, c0, 3, 6, 1'b1, 1'b1, 6);
    wait_until(c0 + 26);

    // inicia held high: second run accepted right after the first completes
    c0      = cyc;
    inicia0 = 1'b1;
    push_tx(0, c0, 3, 6, 1'b1, 1'b0, 0);
    push_tx(0, c0 + 23, 3, 6, 1'b1, 1'b0, 0);
    wait_until(c0 + 30);
    inicia0 = 1'b0;
    wait_until(c0 + 23 + 26);

    // Reset mid-transmission
    start0(1'b0, 3'd0, c0);
    push_tx(0, c0, 3, 3, 1'b0, 1'b0, 0);
    wait_until(c0 + 10);
    reset = 1'b0;
    wait_until(c0 + 11);
    check("abort_numero", numero0, 0);
    check("abort_insere", insere0, 0);
    check("abort_indice", indice0, 0);
    check("abort_ocupado", ocupado0, 0);
    check("abort_fim", fim0, 0);
    wait_until(c0 + 12);
    reset = 1'b1;
    wait_until(c0 + 40);
    start0(1'b0, 3'd0, c0);
    push_tx(0, c0, 3, 6, 1'b1, 1'b0, 0);
    wait_until(c0 + 26);

    // INTERVALO = 1 instance
    c0      = cyc;
    inicia1 = 1'b1;
    @(posedge clk);
    #1;
    inicia1 = 1'b0;
    push_tx(1, c0, 1, 6, 1'b1, 1'b0, 0);
    wait_until(c0 + 12);
    check("i1_ocupado_fim_cycle", ocupado1, 1);
    wait_until(c0 + 16);
    check("i1_ocupado_after", ocupado1, 0);

    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
